// File: rtl/dct_pkg.sv
// Shared constants, FSM state encoding and lane helpers for the 8x8 DCT row/column scheduler.
package dct_pkg;

  localparam int CORE_LAT = 1;
  localparam int IW       = 16;
  localparam int OW       = 12;

  typedef enum logic [2:0] {
    ST_ROW    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_CISSUE = 3'd2,
    ST_CWAIT  = 3'd3,
    ST_COUT   = 3'd4
  } state_e;

  function automatic logic [OW-1:0] lane_ow(input logic [8*OW-1:0] bus, input logic [2:0] k);
    return bus[k*OW +: OW];
  endfunction

  // Re-packs an 8*OW coefficient bus as an 8*IW core input bus, sign-extending each lane.
  function automatic logic [8*IW-1:0] widen_lanes(input logic [8*OW-1:0] bus);
    logic [8*IW-1:0] res;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      res[k*IW +: IW] = {{(IW-OW){bus[k*OW+OW-1]}}, bus[k*OW +: OW]};
    end
    return res;
  endfunction

endpackage

// File: rtl/dct_tbuf.sv
// 8x8 transpose buffer: whole-row write from the row pass, whole-column combinational read.
module dct_tbuf
  import dct_pkg::*;
(
  input  logic            clk,
  input  logic            wr_en_i,
  input  logic [2:0]      wr_row_i,
  input  logic [8*OW-1:0] wr_data_i,
  input  logic [2:0]      rd_col_i,
  output logic [8*OW-1:0] rd_data_o
);

  logic [8*OW-1:0] mem_q [8];

  // Row write; contents need no reset since every block rewrites all rows first.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_row_i] <= wr_data_i;
    end
  end

  // Column read: lane r returns element [r][rd_col_i].
  always_comb begin
    rd_data_o = '0;
    for (int r = 0; r < 8; r++) begin
      rd_data_o[r*OW +: OW] = lane_ow(mem_q[r], rd_col_i);
    end
  end

endmodule

// File: rtl/dct2d_row_col_sched.sv
// Time-shares one 1-D DCT core across the row and column passes of an 8x8 2-D DCT.
module dct2d_row_col_sched
  import dct_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [8*IW-1:0] in_row_i,
  output logic [8*IW-1:0] core_win_o,
  input  logic [8*OW-1:0] core_out_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [8*OW-1:0] out_col_o,
  output logic [2:0]      out_idx_o,
  output logic            busy_o
);

  localparam int             WCW       = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(CORE_LAT - 1);
  localparam logic [2:0]     LAST_IDX  = 3'd7;

  state_e              state_q, state_d;
  logic [2:0]          row_cnt_q, row_cnt_d;
  logic [2:0]          col_cnt_q, col_cnt_d;
  logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [8*OW-1:0]     out_col_q, out_col_d;
  logic [2:0]          out_idx_q, out_idx_d;
  logic [CORE_LAT-1:0] dl_vld_q;
  logic [2:0]          dl_row_q [CORE_LAT];
  logic                push_s;
  logic                dl_pend_s;
  logic [8*OW-1:0]     tbuf_col_s;

  dct_tbuf u_tbuf (
    .clk       (clk),
    .wr_en_i   (dl_vld_q[CORE_LAT-1]),
    .wr_row_i  (dl_row_q[CORE_LAT-1]),
    .wr_data_i (core_out_i),
    .rd_col_i  (col_cnt_q),
    .rd_data_o (tbuf_col_s)
  );

  // Row tags travel alongside the core so each result lands in the right buffer row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dl_vld_q <= '0;
      for (int i = 0; i < CORE_LAT; i++) dl_row_q[i] <= 3'd0;
    end else if (flush_i) begin
      dl_vld_q <= '0;
      for (int i = 0; i < CORE_LAT; i++) dl_row_q[i] <= 3'd0;
    end else begin
      dl_vld_q[0] <= push_s;
      dl_row_q[0] <= row_cnt_q;
      for (int i = 1; i < CORE_LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_row_q[i] <= dl_row_q[i-1];
      end
    end
  end

  // Entries still in flight after this cycle's exit; the exiting one writes the buffer now.
  always_comb begin
    dl_pend_s = 1'b0;
    for (int i = 0; i < CORE_LAT - 1; i++) dl_pend_s = dl_pend_s | dl_vld_q[i];
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_ROW;
      row_cnt_q   <= 3'd0;
      col_cnt_q   <= 3'd0;
      wait_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_idx_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // Next-state logic; flush overrides every other event.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_idx_d   = out_idx_q;
    core_win_o  = '0;
    in_ready_o  = 1'b0;
    push_s      = 1'b0;
    if (flush_i) begin
      state_d     = ST_ROW;
      row_cnt_d   = 3'd0;
      col_cnt_d   = 3'd0;
      wait_cnt_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ROW: begin
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            core_win_o = in_row_i;
            push_s     = 1'b1;
            row_cnt_d  = row_cnt_q + 3'd1;
            if (row_cnt_q == LAST_IDX) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_ROW;
            end
          end else begin
            push_s = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!dl_pend_s) begin
            state_d = ST_CISSUE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_CISSUE: begin
          core_win_o = widen_lanes(tbuf_col_s);
          wait_cnt_d = '0;
          state_d    = ST_CWAIT;
        end
        ST_CWAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            out_col_d   = core_out_i;
            out_idx_d   = col_cnt_q;
            out_valid_d = 1'b1;
            wait_cnt_d  = '0;
            state_d     = ST_COUT;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end
        end
        ST_COUT: begin
          if (out_ready_i) begin
            out_valid_d = 1'b0;
            if (col_cnt_q == LAST_IDX) begin
              col_cnt_d = 3'd0;
              state_d   = ST_ROW;
            end else begin
              col_cnt_d = col_cnt_q + 3'd1;
              state_d   = ST_CISSUE;
            end
          end else begin
            out_valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_ROW;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_col_o   = out_col_q;
  assign out_idx_o   = out_idx_q;
  assign busy_o      = (state_q != ST_ROW) || (row_cnt_q != 3'd0) || (|dl_vld_q);

endmodule

// File: tb/tb_dct2d_row_col_sched.sv
// Bench for dct2d_row_col_sched: small integer 1-D core model plus a matrix-level golden 2-D model.
`timescale 1ns/1ps
module tb_dct2d_row_col_sched;
  import dct_pkg::*;

  logic            clk = 1'b0;
  logic            rstn;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [8*IW-1:0] in_row;
  logic [8*IW-1:0] core_win;
  logic [8*OW-1:0] core_out;
  logic            out_valid;
  logic            out_ready;
  logic [8*OW-1:0] out_col;
  logic [2:0]      out_idx;
  logic            busy;

  always #5 clk = ~clk;

  dct2d_row_col_sched dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_row_i    (in_row),
    .core_win_o  (core_win),
    .core_out_i  (core_out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_col_o   (out_col),
    .out_idx_o   (out_idx),
    .busy_o      (busy)
  );

  int checks = 0;
  int failures = 0;

  // Integer 8-point transform matrix used by the core stand-in and the golden model.
  int cm [8][8] = '{
    '{1,  1,  1,  1,  1,  1,  1,  1},
    '{5,  4,  3,  1, -1, -3, -4, -5},
    '{2,  1, -1, -2, -2, -1,  1,  2},
    '{4, -1, -5, -3,  3,  5,  1, -4},
    '{1, -1, -1,  1,  1, -1, -1,  1},
    '{3, -5,  1,  4, -4, -1,  5, -3},
    '{1, -2,  2, -1, -1,  2, -2,  1},
    '{1, -3,  4, -5,  5, -4,  3, -1}
  };

  function automatic logic [8*OW-1:0] core_fn(input logic [8*IW-1:0] w);
    logic [8*OW-1:0]      res;
    logic signed [IW-1:0] s;
    int                   acc;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int n = 0; n < 8; n++) begin
        s = w[n*IW +: IW];
        acc += cm[k][n] * int'(s);
      end
      res[k*OW +: OW] = acc[OW-1:0];
    end
    return res;
  endfunction

  always_ff @(posedge clk) core_out <= core_fn(core_win);

  function automatic int wrap_ow(input int v);
    logic signed [OW-1:0] t;
    t = v[OW-1:0];
    return int'(t);
  endfunction

  int xs [2][8][8];
  int gd [2][8][8];

  // gd[b][u][v] = wrap(sum_r C[u][r] * wrap(sum_n C[v][n] * x[r][n]))
  function automatic void compute_gold(input int b);
    int y [8][8];
    int acc;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++) acc += cm[k][n] * xs[b][r][n];
        y[r][k] = wrap_ow(acc);
      end
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        acc = 0;
        for (int r = 0; r < 8; r++) acc += cm[u][r] * y[r][v];
        gd[b][u][v] = wrap_ow(acc);
      end
  endfunction

  function automatic logic [8*OW-1:0] gold_col(input int b, input int v);
    logic [8*OW-1:0] res;
    int t;
    for (int u = 0; u < 8; u++) begin
      t = gd[b][u][v];
      res[u*OW +: OW] = t[OW-1:0];
    end
    return res;
  endfunction

  function automatic logic [8*IW-1:0] row_bus(input int b, input int r);
    logic [8*IW-1:0] res;
    int t;
    for (int n = 0; n < 8; n++) begin
      t = xs[b][r][n];
      res[n*IW +: IW] = t[IW-1:0];
    end
    return res;
  endfunction

  function automatic void fill_random(input int b);
    for (int r = 0; r < 8; r++)
      for (int n = 0; n < 8; n++) xs[b][r][n] = int'($urandom_range(0, 255)) - 128;
    compute_gold(b);
  endfunction

  function automatic void fill_const(input int b, input int val);
    for (int r = 0; r < 8; r++)
      for (int n = 0; n < 8; n++) xs[b][r][n] = val;
    compute_gold(b);
  endfunction

  logic [8*OW-1:0] got_col [16];
  int got_idx [16];
  int acc_cyc [16];
  int hand_cyc [16];
  int vld_cyc [16];
  int beats, rows_acc, ready_err, stall_err, ncyc;

  // Drives rows of nblk blocks and collects output beats; records timing and protocol errors.
  task automatic run_block(input int nblk, input int gap_a, input int gap_b, input int gap_len,
                           input int stall_col, input int stall_len, input int stop_rows,
                           input int stop_beats);
    int              gap;
    int              stall_rem;
    bit              prev_stall;
    bit              seen_vld;
    bit              exp_ready;
    logic [8*OW-1:0] held_col;
    logic [2:0]      held_idx;
    beats = 0; rows_acc = 0; ready_err = 0; stall_err = 0; ncyc = 0;
    gap = 0; stall_rem = stall_len; prev_stall = 1'b0; seen_vld = 1'b0;
    held_col = '0; held_idx = 3'd0;
    while (beats < stop_beats && rows_acc < stop_rows && ncyc < 3000) begin
      @(negedge clk);
      if (rows_acc < 8*nblk && gap == 0) begin
        in_valid = 1'b1;
        in_row   = row_bus(rows_acc / 8, rows_acc % 8);
      end else begin
        in_valid = 1'b0;
        if (gap > 0) gap--;
      end
      if (out_valid && stall_rem > 0 && int'(out_idx) == stall_col) begin
        out_ready = 1'b0;
        stall_rem--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      ncyc++;
      if (prev_stall && (out_valid !== 1'b1 || out_col !== held_col || out_idx !== held_idx))
        stall_err++;
      prev_stall = out_valid && !out_ready;
      held_col   = out_col;
      held_idx   = out_idx;
      exp_ready  = !(rows_acc > 0 && rows_acc % 8 == 0 && beats < rows_acc);
      if (in_ready !== exp_ready) ready_err++;
      if (out_valid && !seen_vld) begin
        vld_cyc[beats] = ncyc;
        seen_vld = 1'b1;
      end
      if (in_valid && in_ready) begin
        acc_cyc[rows_acc] = ncyc;
        rows_acc++;
        if (rows_acc == gap_a || rows_acc == gap_b) gap = gap_len;
      end
      if (out_valid && out_ready) begin
        got_col[beats]  = out_col;
        got_idx[beats]  = int'(out_idx);
        hand_cyc[beats] = ncyc;
        beats++;
        seen_vld = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_col !== '0) begin failures++; $display("FAIL reset_out_col got=%h exp=0", out_col); end
    checks++; if (out_idx !== 3'd0) begin failures++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (core_win !== '0) begin failures++; $display("FAIL reset_core_win got=%h exp=0", core_win); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_dc();
    logic [OW-1:0] f00;
    fill_const(0, 8);
    run_block(1, -1, -1, 0, -1, 0, 99, 8);
    checks++; if (beats !== 8) begin failures++; $display("FAIL dc_beats got=%0d exp=8", beats); end
    f00 = got_col[0][OW-1:0];
    checks++; if (f00 !== 12'd512) begin failures++; $display("FAIL dc_f00 got=%0d exp=512", f00); end
    checks++; if (got_col[0][8*OW-1:OW] !== '0) begin failures++; $display("FAIL dc_col0_ac got=%h exp=0", got_col[0]); end
    for (int v = 1; v < 8; v++) begin
      checks++; if (got_col[v] !== '0) begin failures++; $display("FAIL dc_col%0d got=%h exp=0", v, got_col[v]); end
    end
    for (int v = 0; v < 8; v++) begin
      checks++; if (got_idx[v] !== v) begin failures++; $display("FAIL dc_idx%0d got=%0d exp=%0d", v, got_idx[v], v); end
    end
    checks++; if (vld_cyc[0] - acc_cyc[7] !== 2*CORE_LAT+2) begin
      failures++; $display("FAIL dc_block_latency got=%0d exp=%0d", vld_cyc[0] - acc_cyc[7], 2*CORE_LAT+2);
    end
    for (int v = 0; v < 7; v++) begin
      checks++; if (hand_cyc[v+1] - hand_cyc[v] !== 2+CORE_LAT) begin
        failures++; $display("FAIL dc_col_period%0d got=%0d exp=%0d", v, hand_cyc[v+1] - hand_cyc[v], 2+CORE_LAT);
      end
    end
    checks++; if (ready_err !== 0) begin failures++; $display("FAIL dc_in_ready errors=%0d exp=0", ready_err); end
  endtask

  task automatic test_impulse();
    int extra;
    fill_const(0, 0);
    xs[0][0][0] = 64;
    compute_gold(0);
    run_block(1, -1, -1, 0, -1, 0, 99, 8);
    checks++; if (beats !== 8) begin failures++; $display("FAIL imp_beats got=%0d exp=8", beats); end
    for (int v = 0; v < 8; v++) begin
      checks++; if (got_col[v] !== gold_col(0, v)) begin
        failures++; $display("FAIL imp_col%0d got=%h exp=%h", v, got_col[v], gold_col(0, v));
      end
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk); #1;
      if (out_valid) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL imp_extra_beats got=%0d exp=0", extra); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL imp_busy_idle got=%b exp=0", busy); end
  endtask

  task automatic test_gaps();
    fill_random(0);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) run_block(1, -1, -1, 0, -1, 0, 99, 8);
      else           run_block(1, 3, 6, 5, -1, 0, 99, 8);
      checks++; if (beats !== 8) begin failures++; $display("FAIL gap%0d_beats got=%0d exp=8", pass, beats); end
      for (int v = 0; v < 8; v++) begin
        checks++; if (got_col[v] !== gold_col(0, v)) begin
          failures++; $display("FAIL gap%0d_col%0d got=%h exp=%h", pass, v, got_col[v], gold_col(0, v));
        end
      end
      checks++; if (ready_err !== 0) begin failures++; $display("FAIL gap%0d_in_ready errors=%0d exp=0", pass, ready_err); end
    end
    checks++; if (acc_cyc[3] - acc_cyc[2] !== 6) begin
      failures++; $display("FAIL gap_row3_spacing got=%0d exp=6", acc_cyc[3] - acc_cyc[2]);
    end
  endtask

  task automatic test_stall();
    fill_random(0);
    run_block(1, -1, -1, 0, 2, 10, 99, 8);
    checks++; if (beats !== 8) begin failures++; $display("FAIL stall_beats got=%0d exp=8", beats); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL stall_hold errors=%0d exp=0", stall_err); end
    checks++; if (hand_cyc[2] - vld_cyc[2] !== 10) begin
      failures++; $display("FAIL stall_len got=%0d exp=10", hand_cyc[2] - vld_cyc[2]);
    end
    for (int v = 0; v < 8; v++) begin
      checks++; if (got_idx[v] !== v || got_col[v] !== gold_col(0, v)) begin
        failures++; $display("FAIL stall_col%0d idx=%0d got=%h exp_idx=%0d exp=%h", v, got_idx[v], got_col[v], v, gold_col(0, v));
      end
    end
  endtask

  task automatic test_flush();
    logic [OW-1:0] f00;
    fill_random(0);
    run_block(1, -1, -1, 0, -1, 0, 99, 4);
    checks++; if (beats !== 4) begin failures++; $display("FAIL flush_pre_beats got=%0d exp=4", beats); end
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_row = row_bus(0, 1);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    fill_const(0, 8);
    run_block(1, -1, -1, 0, -1, 0, 99, 8);
    checks++; if (beats !== 8) begin failures++; $display("FAIL flush_post_beats got=%0d exp=8", beats); end
    f00 = got_col[0][OW-1:0];
    checks++; if (f00 !== 12'd512) begin failures++; $display("FAIL flush_post_f00 got=%0d exp=512", f00); end
    for (int v = 0; v < 8; v++) begin
      checks++; if (got_idx[v] !== v || got_col[v] !== gold_col(0, v)) begin
        failures++; $display("FAIL flush_post_col%0d idx=%0d got=%h exp=%h", v, got_idx[v], got_col[v], gold_col(0, v));
      end
    end
  endtask

  task automatic test_rstn_mid();
    fill_random(0);
    run_block(1, -1, -1, 0, -1, 0, 6, 8);
    checks++; if (rows_acc !== 6) begin failures++; $display("FAIL rst_rows got=%0d exp=6", rows_acc); end
    @(negedge clk);
    in_valid = 1'b0; rstn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (out_col !== '0 || out_idx !== 3'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_outputs col=%h idx=%0d vld=%b exp=0", out_col, out_idx, out_valid);
    end
    checks++; if (core_win !== '0) begin failures++; $display("FAIL rst_core_win got=%h exp=0", core_win); end
    @(negedge clk);
    rstn = 1'b1;
    fill_random(0);
    run_block(1, -1, -1, 0, -1, 0, 99, 8);
    checks++; if (beats !== 8) begin failures++; $display("FAIL rst_post_beats got=%0d exp=8", beats); end
    for (int v = 0; v < 8; v++) begin
      checks++; if (got_idx[v] !== v || got_col[v] !== gold_col(0, v)) begin
        failures++; $display("FAIL rst_post_col%0d idx=%0d got=%h exp=%h", v, got_idx[v], got_col[v], gold_col(0, v));
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_random(0);
    fill_random(1);
    run_block(2, -1, -1, 0, -1, 0, 99, 16);
    checks++; if (beats !== 16) begin failures++; $display("FAIL b2b_beats got=%0d exp=16", beats); end
    checks++; if (acc_cyc[8] !== hand_cyc[7] + 1) begin
      failures++; $display("FAIL b2b_restart got=%0d exp=%0d", acc_cyc[8], hand_cyc[7] + 1);
    end
    checks++; if (ready_err !== 0) begin failures++; $display("FAIL b2b_in_ready errors=%0d exp=0", ready_err); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_idx[i] !== i % 8 || got_col[i] !== gold_col(i / 8, i % 8)) begin
        failures++; $display("FAIL b2b_beat%0d idx=%0d got=%h exp=%h", i, got_idx[i], got_col[i], gold_col(i / 8, i % 8));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dc();
    test_impulse();
    test_gaps();
    test_stall();
    test_flush();
    test_rstn_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
